// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage of the pipelined RISC-V core.
//
// This is the only driver of the register-file write port. It takes retiring
// instructions from the MEM stage over a valid/ready handshake and picks the
// result source: ALU, load data, or PC+4. A load parks the stage in WAIT_LOAD
// until the data-memory response arrives. The returned word is then formatted
// as a byte, halfword or word, with sign or zero extension. A bounded wait
// timeout turns a lost response into a one-cycle load_err pulse, so the
// pipeline cannot hang.
//
// Parameters
//   TIMEOUT_CYCLES  maximum number of cycles spent in WAIT_LOAD (0 = no timeout)
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   in_valid       in   MEM stage presents an instruction
//   in_ready       out  stage can accept (1 in IDLE, combinational from state)
//   in_rd          in   destination register
//   in_reg_we      in   instruction writes rd
//   in_wb_sel      in   00 ALU, 01 load, 10 PC+4, 11 treated as ALU
//   in_alu_result  in   ALU result
//   in_pc_plus4    in   link value
//   in_funct3      in   load width/sign
//   in_addr_lo     in   low two bits of the load address
//   dmem_rvalid    in   load data valid (single-cycle pulse)
//   dmem_rdata     in   raw aligned memory word
//   write_en       out  register-file write strobe (one cycle per result)
//   write_addr     out  register-file write address
//   write_value    out  register-file write data
//   load_err       out  one-cycle pulse on load timeout
//
// Optional feature (macro WB_FORWARD_EN):
//   fwd_valid/fwd_addr/fwd_value  mirror of the write port, for decode bypass
//   fwd_pending/fwd_pending_addr  a load to a nonzero rd is outstanding
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_we,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        write_en,
  output logic [4:0]  write_addr,
  output logic [31:0] write_value,
  output logic        load_err
`ifdef WB_FORWARD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_value,
  output logic        fwd_pending,
  output logic [4:0]  fwd_pending_addr
`endif
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

  // Extract and extend the addressed byte or halfword of the memory word.
  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = w[7:0];
    endcase
    // addr_lo[0] is deliberately ignored for halfwords.
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h00_0000, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0000, h};
      default: fmt_load = w;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic             ld_we_q, ld_we_d;
  logic [2:0]       ld_f3_q, ld_f3_d;
  logic [1:0]       ld_lo_q, ld_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      val_q, val_d;
  logic             err_q, err_d;
  logic             tmo_hit;

  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);
  assign in_ready = (state_q == IDLE);

  // Next-state and next-output logic for the IDLE / WAIT_LOAD controller.
  always_comb begin
    state_d = state_q;
    ld_rd_d = ld_rd_q;
    ld_we_d = ld_we_q;
    ld_f3_d = ld_f3_q;
    ld_lo_d = ld_lo_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    val_d   = val_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // dmem_rvalid is not looked at here: a stray response is ignored.
        if (in_valid) begin
          if (in_wb_sel == 2'b01) begin
            ld_rd_d = in_rd;
            ld_we_d = in_reg_we;
            ld_f3_d = in_funct3;
            ld_lo_d = in_addr_lo;
            cnt_d   = {CNT_W{1'b0}};
            state_d = WAIT_LOAD;
          end else begin
            we_d   = in_reg_we && (in_rd != 5'd0);
            addr_d = in_rd;
            val_d  = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LOAD: begin
        // A response in the timeout cycle still wins over the error.
        if (dmem_rvalid) begin
          we_d    = ld_we_q && (ld_rd_q != 5'd0);
          addr_d  = ld_rd_q;
          val_d   = fmt_load(ld_f3_q, ld_lo_q, dmem_rdata);
          state_d = IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched load context and registered write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ld_rd_q <= 5'd0;
      ld_we_q <= 1'b0;
      ld_f3_q <= 3'd0;
      ld_lo_q <= 2'd0;
      cnt_q   <= {CNT_W{1'b0}};
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      val_q   <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_rd_q <= ld_rd_d;
      ld_we_q <= ld_we_d;
      ld_f3_q <= ld_f3_d;
      ld_lo_q <= ld_lo_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign write_en    = we_q;
  assign write_addr  = addr_q;
  assign write_value = val_q;
  assign load_err    = err_q;

`ifdef WB_FORWARD_EN
  logic pending;

  assign pending          = (state_q == WAIT_LOAD) && ld_we_q && (ld_rd_q != 5'd0);
  assign fwd_valid        = we_q;
  assign fwd_addr         = addr_q;
  assign fwd_value        = val_q;
  assign fwd_pending      = pending;
  assign fwd_pending_addr = pending ? ld_rd_q : 5'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- directed self-checking bench for wb_stage (TIMEOUT_CYCLES = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_value;
  logic        load_err;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_value;
  logic        fwd_pending;
  logic [4:0]  fwd_pending_addr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_reg_we     (in_reg_we),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_value   (write_value),
    .load_err      (load_err)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid        (fwd_valid),
    .fwd_addr         (fwd_addr),
    .fwd_value        (fwd_value),
    .fwd_pending      (fwd_pending),
    .fwd_pending_addr (fwd_pending_addr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3,
                       input logic [1:0] lo);
    in_valid      = v;
    in_rd         = rd;
    in_reg_we     = we;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_pc_plus4   = pc4;
    in_funct3     = f3;
    in_addr_lo    = lo;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 3'd0, 2'd0);
  endtask

  // Accept a load, return rdata 'gap' cycles after acceptance, then check the write.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] rdata, input int gap,
                         input logic exp_we, input logic [31:0] exp_val);
    drive(1'b1, rd, 1'b1, 2'b01, 32'hDEAD_BEEF, 32'h0, f3, lo);
    tick();
    idle_in();
    for (int i = 1; i < gap; i++) tick();
    check({tag, "_ready_wait"}, {31'd0, in_ready}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    check({tag, "_we"}, {31'd0, write_en}, {31'd0, exp_we});
    if (exp_we) begin
      check({tag, "_addr"}, {27'd0, write_addr}, {27'd0, rd});
      check({tag, "_val"}, write_value, exp_val);
    end else begin
      check({tag, "_noerr"}, {31'd0, load_err}, 32'd0);
    end
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    idle_in();
    tick();
    tick();
    check("rst_we", {31'd0, write_en}, 32'd0);
    check("rst_addr", {27'd0, write_addr}, 32'd0);
    check("rst_val", write_value, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    tick();

    // Single ALU op.
    drive(1'b1, 5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h0000_0010, 3'd0, 2'd0);
    tick();
    idle_in();
    check("alu_we", {31'd0, write_en}, 32'd1);
    check("alu_addr", {27'd0, write_addr}, 32'd5);
    check("alu_val", write_value, 32'h0000_1234);
`ifdef WB_FORWARD_EN
    check("fwd_valid", {31'd0, fwd_valid}, 32'd1);
    check("fwd_value", fwd_value, 32'h0000_1234);
`endif
    tick();
    check("alu_we_drop", {31'd0, write_en}, 32'd0);

    // Three back-to-back ALU ops.
    drive(1'b1, 5'd1, 1'b1, 2'b00, 32'h0000_0011, 32'h0, 3'd0, 2'd0);
    check("b2b_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    check("b2b_we1", {31'd0, write_en}, 32'd1);
    check("b2b_v1", write_value, 32'h0000_0011);
    drive(1'b1, 5'd2, 1'b1, 2'b00, 32'h0000_0022, 32'h0, 3'd0, 2'd0);
    check("b2b_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    check("b2b_we2", {31'd0, write_en}, 32'd1);
    check("b2b_a2", {27'd0, write_addr}, 32'd2);
    check("b2b_v2", write_value, 32'h0000_0022);
    drive(1'b1, 5'd3, 1'b1, 2'b00, 32'h0000_0033, 32'h0, 3'd0, 2'd0);
    check("b2b_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    idle_in();
    check("b2b_we3", {31'd0, write_en}, 32'd1);
    check("b2b_a3", {27'd0, write_addr}, 32'd3);
    check("b2b_v3", write_value, 32'h0000_0033);
    tick();
    check("b2b_we_drop", {31'd0, write_en}, 32'd0);

    // Loads: formatting and latency.
    do_load("lb", 5'd7, 3'b000, 2'd2, 32'h00F0_0000, 3, 1'b1, 32'hFFFF_FFF0);
    do_load("lhu", 5'd8, 3'b101, 2'd2, 32'h8001_0000, 1, 1'b1, 32'h0000_8001);
    do_load("lh", 5'd9, 3'b001, 2'd1, 32'h1234_8001, 2, 1'b1, 32'hFFFF_8001);
    do_load("lbu", 5'd10, 3'b100, 2'd3, 32'hAB00_0000, 1, 1'b1, 32'h0000_00AB);
    do_load("lw", 5'd11, 3'b010, 2'd0, 32'h89AB_CDEF, 2, 1'b1, 32'h89AB_CDEF);
    do_load("lx0", 5'd0, 3'b010, 2'd0, 32'h5555_5555, 1, 1'b0, 32'h0);

    // rd = 0 ALU op, JAL link value, reserved select.
    drive(1'b1, 5'd0, 1'b1, 2'b00, 32'h0000_7777, 32'h0, 3'd0, 2'd0);
    tick();
    idle_in();
    check("x0_we", {31'd0, write_en}, 32'd0);
    drive(1'b1, 5'd1, 1'b1, 2'b10, 32'h0000_DEAD, 32'h0000_0104, 3'd0, 2'd0);
    tick();
    idle_in();
    check("jal_we", {31'd0, write_en}, 32'd1);
    check("jal_val", write_value, 32'h0000_0104);
    drive(1'b1, 5'd4, 1'b1, 2'b11, 32'h0000_4444, 32'h0000_0999, 3'd0, 2'd0);
    tick();
    idle_in();
    check("rsv_val", write_value, 32'h0000_4444);

    // Timeout: no response, error after four waiting cycles.
    drive(1'b1, 5'd12, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
    tick();
    idle_in();
    tick();
    tick();
    tick();
    check("tmo_err_early", {31'd0, load_err}, 32'd0);
    check("tmo_ready_wait", {31'd0, in_ready}, 32'd0);
    tick();
    check("tmo_err", {31'd0, load_err}, 32'd1);
    check("tmo_we", {31'd0, write_en}, 32'd0);
    check("tmo_ready", {31'd0, in_ready}, 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_1111;
    tick();
    dmem_rvalid = 1'b0;
    check("tmo_err_pulse", {31'd0, load_err}, 32'd0);
    check("late_rvalid_we", {31'd0, write_en}, 32'd0);
    check("late_rvalid_ready", {31'd0, in_ready}, 32'd1);

    // Response in the timeout cycle wins.
    do_load("race", 5'd13, 3'b010, 2'd0, 32'h2468_ACE0, 4, 1'b1, 32'h2468_ACE0);
    check("race_noerr", {31'd0, load_err}, 32'd0);

    // Reset while waiting for a load.
    drive(1'b1, 5'd9, 1'b1, 2'b00, 32'h0000_CAFE, 32'h0, 3'd0, 2'd0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
    tick();
    idle_in();
    check("pre_rst_val", write_value, 32'h0000_CAFE);
`ifdef WB_FORWARD_EN
    check("fwd_pending", {31'd0, fwd_pending}, 32'd1);
    check("fwd_pending_addr", {27'd0, fwd_pending_addr}, 32'd7);
`endif
    #2;
    reset = 1'b1;
    #1;
    check("arst_val", write_value, 32'd0);
    check("arst_addr", {27'd0, write_addr}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
`ifdef WB_FORWARD_EN
    check("arst_fwd_pending", {31'd0, fwd_pending}, 32'd0);
`endif
    tick();
    reset = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h3333_3333;
    tick();
    dmem_rvalid = 1'b0;
    check("post_rst_we", {31'd0, write_en}, 32'd0);
    check("post_rst_err", {31'd0, load_err}, 32'd0);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
